// File: rtl/vga_pkg.sv
// Shared definitions for the VGA timing decoder: default 640x480@60 timing,
// decoder state encoding and the CRC-16-CCITT word update.
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // One 16-bit word folded into a CCITT CRC (poly 0x1021), MSB first.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc_in,
                                               input logic [15:0] word);
        logic [15:0] c;
        c = crc_in;
        for (int i = 15; i >= 0; i--) begin
            if (c[15] ^ word[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else                 c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/vga_crc16.sv
// Running CRC-16-CCITT over one 16-bit word per enabled cycle. 'clear'
// restarts from the 0xFFFF seed and folds in the word of the same cycle,
// so the first beat of a frame is included in that frame's CRC.
module vga_crc16 import vga_pkg::*; (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        clear,
    input  logic [15:0] data,
    output logic [15:0] crc
);

    // Accumulate one word per enabled cycle, reseeding on clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            crc <= 16'hFFFF;
        end else if (ce) begin
            crc <= crc16_step(clear ? 16'hFFFF : crc, data);
        end
    end

endmodule

// File: rtl/vga_timing_decoder.sv
// Sink-side VGA decoder. Samples hsync/vsync/rgb on pix_ce, tracks the raster
// position, locks to the frame timing and emits visible pixel beats together
// with line/frame/blanking violation pulses.
// Optional feature: define VGA_CRC_EN to compute a CRC-16 over each clean
// frame's pixels (frame_crc); without it frame_crc is constant zero.
module vga_timing_decoder import vga_pkg::*; #(
    parameter int   H_ACTIVE = VGA_H_ACTIVE,
    parameter int   H_FP     = VGA_H_FP,
    parameter int   H_SYNC   = VGA_H_SYNC,
    parameter int   H_BP     = VGA_H_BP,
    parameter int   V_ACTIVE = VGA_V_ACTIVE,
    parameter int   V_FP     = VGA_V_FP,
    parameter int   V_SYNC   = VGA_V_SYNC,
    parameter int   V_BP     = VGA_V_BP,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_ce,
    input  logic        vga_hs,
    input  logic        vga_vs,
    input  logic [3:0]  vga_r,
    input  logic [3:0]  vga_g,
    input  logic [3:0]  vga_b,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [11:0] pix_rgb,
    output logic        frame_start,
    output logic        frame_done,
    output logic        locked,
    output logic        line_err,
    output logic        frame_err,
    output logic        blank_err,
    output logic [15:0] frame_cnt,
    output logic [15:0] frame_crc
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_TOT_C  = HW'(H_TOTAL);
    localparam logic [HW-1:0] H_VIS_LO = HW'(H_SYNC + H_BP);
    localparam logic [HW-1:0] H_VIS_HI = HW'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [VW-1:0] V_TOT_C  = VW'(V_TOTAL);
    localparam logic [VW-1:0] V_VIS_LO = VW'(V_SYNC + V_BP);
    localparam logic [VW-1:0] V_VIS_HI = VW'(V_SYNC + V_BP + V_ACTIVE);

    state_t        state;
    logic          hs_prev;     // previous sample had hsync asserted
    logic          vs_prev;     // previous sample had vsync asserted
    logic [HW-1:0] h_cnt;       // position of the previous sample in its line
    logic [VW-1:0] v_cnt;       // line index of the previous sample in its frame
    logic          armed;       // an hs edge has been seen since leaving SEARCH
    logic          sync_err;    // line error seen in the frame being qualified
    logic          frame_bad;   // any error seen in the current frame

    state_t        state_nx;
    logic          hs_a, vs_a, hs_edge, vs_edge;
    logic [HW-1:0] h_cur;
    logic [VW-1:0] v_cur;
    logic [HW:0]   line_len;
    logic [VW:0]   frame_len;
    logic [11:0]   rgb_in;
    logic          visible;
    logic          ln_err_c, fr_err_c, bl_err_c, beat_c, start_c, done_c;

    // Edge detection, raster position of the current sample and event decode.
    always_comb begin
        rgb_in    = {vga_r, vga_g, vga_b};
        hs_a      = (vga_hs == HS_POL);
        vs_a      = (vga_vs == VS_POL);
        hs_edge   = hs_a && !hs_prev;
        vs_edge   = vs_a && !vs_prev;
        line_len  = {1'b0, h_cnt} + 1'b1;
        frame_len = {1'b0, v_cnt} + 1'b1;

        h_cur = h_cnt;
        if (hs_edge)               h_cur = '0;
        else if (h_cnt != H_TOT_C) h_cur = h_cnt + 1'b1;

        // A coincident hs+vs sample advances the line and then restarts the frame.
        v_cur = v_cnt;
        if (hs_edge && v_cnt != V_TOT_C) v_cur = v_cnt + 1'b1;
        if (vs_edge)                     v_cur = '0;

        visible  = (h_cur >= H_VIS_LO) && (h_cur < H_VIS_HI) &&
                   (v_cur >= V_VIS_LO) && (v_cur < V_VIS_HI);
        ln_err_c = hs_edge && (state != SEARCH) && armed &&
                   (line_len != {1'b0, H_TOT_C});
        fr_err_c = vs_edge && (state == LOCKED) && (frame_len != {1'b0, V_TOT_C});
        bl_err_c = (state == LOCKED) && !visible && (rgb_in != 12'h000);
        beat_c   = (state == LOCKED) && visible;
        start_c  = beat_c && (h_cur == H_VIS_LO) && (v_cur == V_VIS_LO);
        done_c   = vs_edge && (state == LOCKED) && (frame_len == {1'b0, V_TOT_C}) &&
                   !frame_bad && !ln_err_c && !bl_err_c;

        state_nx = state;
        case (state)
            SEARCH: if (vs_edge) state_nx = SYNC;
            SYNC:   if (vs_edge && (frame_len == {1'b0, V_TOT_C}) && !sync_err && !ln_err_c)
                        state_nx = LOCKED;
            LOCKED: if (ln_err_c || fr_err_c) state_nx = SYNC;
            default: state_nx = SEARCH;
        endcase
    end

    // Decoder state, raster counters and all registered outputs except the CRC.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SEARCH;
            hs_prev     <= 1'b0;
            vs_prev     <= 1'b0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            armed       <= 1'b0;
            sync_err    <= 1'b0;
            frame_bad   <= 1'b0;
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_rgb     <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            locked      <= 1'b0;
            line_err    <= 1'b0;
            frame_err   <= 1'b0;
            blank_err   <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            line_err    <= 1'b0;
            frame_err   <= 1'b0;
            blank_err   <= 1'b0;
            if (pix_ce) begin
                state     <= state_nx;
                hs_prev   <= hs_a;
                vs_prev   <= vs_a;
                h_cnt     <= h_cur;
                v_cnt     <= v_cur;
                armed     <= (state == SEARCH) ? 1'b0 : (armed | hs_edge);
                sync_err  <= vs_edge ? 1'b0 : (sync_err | ln_err_c);
                frame_bad <= vs_edge ? 1'b0 : (frame_bad | ln_err_c | bl_err_c);
                pix_valid   <= beat_c;
                frame_start <= start_c;
                frame_done  <= done_c;
                line_err    <= ln_err_c;
                frame_err   <= fr_err_c;
                blank_err   <= bl_err_c;
                locked      <= (state_nx == LOCKED);
                if (beat_c) begin
                    pix_x   <= 10'(h_cur - H_VIS_LO);
                    pix_y   <= 10'(v_cur - V_VIS_LO);
                    pix_rgb <= rgb_in;
                end
                if (done_c) frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

`ifdef VGA_CRC_EN
    logic [15:0] crc_run;

    vga_crc16 u_crc (
        .clk   (clk),
        .rst   (rst),
        .ce    (pix_ce && beat_c),
        .clear (start_c),
        .data  ({4'h0, rgb_in}),
        .crc   (crc_run)
    );

    // Publish the running CRC when a clean locked frame closes.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_crc <= 16'h0000;
        end else if (pix_ce && done_c) begin
            frame_crc <= crc_run;
        end
    end
`else
    assign frame_crc = 16'h0000;
`endif

endmodule
